// File: rtl/spi_shift_register_param.sv
// Parametrised full-duplex SPI master shift register, CPOL/CPHA modes 0..3.
// Optional SPI_SR_LOOPBACK_EN adds a loopback input that samples mosi internally.
module spi_shift_register_param #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic              receive_data,
  input  logic              miso,
`ifdef SPI_SR_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              cpol,
  input  logic              cphase,
  input  logic              lsbfe,
  input  logic [CNT_W-1:0]  word_len,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              flag_low,
  input  logic              flag_high,
  input  logic              flags_low,
  input  logic              flags_high,
  output logic [DATA_W-1:0] data_miso,
  output logic              mosi,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] NMAX = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t            state_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] data_miso_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  lcnt_q;
  logic              lsb_q;
  logic              mode_q;
  logic              skip_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  n_ld;
  logic [CNT_W-1:0]  ld_idx;
  logic [CNT_W-1:0]  nm1;
  logic [CNT_W-1:0]  sidx;
  logic [CNT_W-1:0]  lnext;
  logic [CNT_W-1:0]  tidx;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] bit_oh;
  logic [DATA_W-1:0] rx_nxt;
  logic [DATA_W-1:0] len_mask;
  logic              sample;
  logic              launch;
  logic              rx_bit;

  always_comb begin
    n_ld = word_len;
    if (word_len == '0 || word_len > NMAX) begin
      n_ld = NMAX;
    end
    ld_idx   = lsbfe ? '0 : n_ld - ONE;
    ld_sh    = data_mosi >> ld_idx;
    nm1      = n_q - ONE;
    sidx     = lsb_q ? cnt_q : nm1 - cnt_q;
    lnext    = lcnt_q + ONE;
    tidx     = lsb_q ? lnext : nm1 - lnext;
    tx_sh    = tx_q >> tidx;
    sample   = mode_q ? flags_high : flags_low;
    launch   = mode_q ? flag_low : flag_high;
`ifdef SPI_SR_LOOPBACK_EN
    rx_bit   = loopback ? mosi_q : miso;
`else
    rx_bit   = miso;
`endif
    bit_oh   = {{(DATA_W-1){1'b0}}, rx_bit} << sidx;
    rx_nxt   = rx_q | bit_oh;
    len_mask = ~({DATA_W{1'b1}} << n_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      data_miso_q <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      lcnt_q      <= '0;
      lsb_q       <= 1'b0;
      mode_q      <= 1'b0;
      skip_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          mosi_q <= 1'b0;
          busy_q <= 1'b0;
          if (send_data && !ss) begin
            tx_q    <= data_mosi;
            rx_q    <= '0;
            n_q     <= n_ld;
            lsb_q   <= lsbfe;
            mode_q  <= (cpol == cphase);
            skip_q  <= cphase;
            cnt_q   <= '0;
            lcnt_q  <= '0;
            mosi_q  <= ld_sh[0];
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (ss) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            lcnt_q  <= '0;
          end else begin
            // cphase=1 presents bit 0 at load, so its leading launch is a no-op
            if (launch) begin
              if (skip_q) begin
                skip_q <= 1'b0;
              end else if (lcnt_q != nm1) begin
                lcnt_q <= lnext;
                mosi_q <= tx_sh[0];
              end
            end
            if (sample) begin
              rx_q  <= rx_nxt;
              cnt_q <= cnt_q + ONE;
              if (cnt_q == nm1) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                if (receive_data) begin
                  data_miso_q <= rx_nxt & len_mask;
                end
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          lcnt_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_miso = data_miso_q;
  assign mosi      = mosi_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_shift_register_param.sv
// Directed bench for spi_shift_register_param (DATA_W=16).
// Loopback frames run only when SPI_SR_LOOPBACK_EN is defined.
module tb_spi_shift_register_param;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        ss;
  logic        send_data;
  logic        receive_data;
  logic        miso;
  logic        cpol;
  logic        cphase;
  logic        lsbfe;
  logic [4:0]  word_len;
  logic [15:0] data_mosi;
  logic        flag_low;
  logic        flag_high;
  logic        flags_low;
  logic        flags_high;
  logic [15:0] data_miso;
  logic        mosi;
  logic        busy;
  logic        done;
`ifdef SPI_SR_LOOPBACK_EN
  logic        loopback;
`endif

  int errors = 0;
  int checks = 0;
  int done_total = 0;

  spi_shift_register_param #(.DATA_W(16)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .ss(ss),
    .send_data(send_data),
    .receive_data(receive_data),
    .miso(miso),
`ifdef SPI_SR_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cpol(cpol),
    .cphase(cphase),
    .lsbfe(lsbfe),
    .word_len(word_len),
    .data_mosi(data_mosi),
    .flag_low(flag_low),
    .flag_high(flag_high),
    .flags_low(flags_low),
    .flags_high(flags_high),
    .data_miso(data_miso),
    .mosi(mosi),
    .busy(busy),
    .done(done)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    #1;
    if (done) done_total++;
  end

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic        lsb;
    logic        recv;
    logic [4:0]  wl;
    int          n;
    logic [15:0] tx;
    logic [15:0] ser;
    logic [15:0] exp_mosi;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t tv[10];
  vec_t hv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic m, input logic smp);
    if (smp) begin
      if (m) flags_high = 1'b1;
      else   flags_low  = 1'b1;
    end else begin
      if (m) flag_low  = 1'b1;
      else   flag_high = 1'b1;
    end
    @(negedge PCLK);
    {flag_low, flag_high, flags_low, flags_high} = '0;
  endtask

  task automatic run_frame(input vec_t v, input int poke_at,
                           input int abort_at);
    logic [15:0] obs;
    logic [15:0] prev;
    logic        m;
    int          base;
    obs          = '0;
    prev         = data_miso;
    m            = (v.cpol == v.cpha);
    cpol         = v.cpol;
    cphase       = v.cpha;
    lsbfe        = v.lsb;
    word_len     = v.wl;
    data_mosi    = v.tx;
    receive_data = v.recv;
    ss           = 1'b0;
    base         = done_total;
    send_data    = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    chk("busy_load", 32'(busy), 32'd1);
    for (int i = 0; i < v.n; i++) begin
      if (i == abort_at) begin
        ss = 1'b1;
        @(negedge PCLK);
        chk("abort_outs", 32'({busy, done, mosi}), 32'd0);
        chk("abort_miso", 32'(data_miso), 32'(prev));
        @(negedge PCLK);
        ss = 1'b0;
        chk("abort_no_done", 32'(done_total - base), 32'd0);
        return;
      end
      if (i == poke_at) begin
        data_mosi = ~v.tx;
        cpol      = ~v.cpol;
        cphase    = ~v.cpha;
        lsbfe     = ~v.lsb;
        word_len  = 5'd3;
        send_data = 1'b1;
        @(negedge PCLK);
        send_data = 1'b0;
        chk("poke_busy", 32'(busy), 32'd1);
      end
      if (v.cpha) pulse(m, 1'b0);
      obs[v.n-1-i] = mosi;
      miso = v.ser[v.n-1-i];
      pulse(m, 1'b1);
      if (!v.cpha && i < v.n - 1) pulse(m, 1'b0);
    end
    chk("done_hi", 32'({done, busy}), 32'd2);
    chk("data_miso", 32'(data_miso), 32'(v.exp_miso));
    chk("mosi_seq", 32'(obs), 32'(v.exp_mosi));
    @(negedge PCLK);
    chk("done_lo", 32'(done), 32'd0);
    chk("done_count", 32'(done_total - base), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // cpol cpha lsb recv wl n tx ser exp_mosi exp_miso
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  8,  16'h0075, 16'h0063, 16'h0075, 16'h0063};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  8,  16'h0075, 16'h00C6, 16'h00AE, 16'h0063};
    tv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 12, 16'h0ABC, 16'h0FFF, 16'h0ABC, 16'h0FFF};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  8,  16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  5,  16'h0013, 16'h0016, 16'h0019, 16'h000D};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  16, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    tv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 16, 16'h8001, 16'h00FF, 16'h8001, 16'hFF00};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1,  16'hFFFE, 16'h0001, 16'h0000, 16'h0001};
    tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  8,  16'h000F, 16'h00AA, 16'h000F, 16'h0001};
    tv[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  8,  16'h003C, 16'h0081, 16'h003C, 16'h0081};

    PRESETn = 1'b0;
    ss = 1'b1;
    send_data = 1'b0;
    receive_data = 1'b0;
    miso = 1'b0;
    cpol = 1'b0;
    cphase = 1'b0;
    lsbfe = 1'b0;
    word_len = '0;
    data_mosi = '0;
    {flag_low, flag_high, flags_low, flags_high} = '0;
`ifdef SPI_SR_LOOPBACK_EN
    loopback = 1'b0;
`endif
    #13;
    chk("reset_outs", 32'({data_miso, mosi, busy, done}), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int k = 0; k < 10; k++) begin
      run_frame(tv[k], -1, -1);
    end

    // abort in mode 1 keeps the previous word, next frame recovers
    run_frame(tv[0], -1, -1);
    hv = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 8, 16'h00F0, 16'h00FF, 16'h0000, 16'h0000};
    run_frame(hv, -1, 3);
    hv = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 8, 16'h005A, 16'h005A, 16'h005A, 16'h005A};
    run_frame(hv, -1, -1);

    // reload and config changes mid-frame must be ignored
    hv = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 8, 16'h0096, 16'h0069, 16'h0096, 16'h0069};
    run_frame(hv, 3, -1);

    // asynchronous reset in the middle of a frame
    cpol = 1'b0;
    cphase = 1'b0;
    lsbfe = 1'b0;
    word_len = 5'd8;
    data_mosi = 16'h00FF;
    ss = 1'b0;
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    chk("pre_reset", 32'({mosi, busy}), 32'd3);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_reset", 32'({data_miso, mosi, busy, done}), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    run_frame(tv[0], -1, -1);

`ifdef SPI_SR_LOOPBACK_EN
    loopback = 1'b1;
    for (int md = 0; md < 4; md++) begin
      hv = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 8, 16'h00C3, 16'h0000, 16'h00C3, 16'h00C3};
      hv.cpol = md[1];
      hv.cpha = md[0];
      run_frame(hv, -1, -1);
    end
    loopback = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
